// File: rtl/tx_in_buffer_pkg.sv
// Shared constants and FSM state types for the tx_in_buffer AXI4-Lite TX payload queue.
package tx_in_buffer_pkg;

   localparam logic [3:0] ADDR_DATA    = 4'h0;
   localparam logic [3:0] ADDR_STATUS  = 4'h4;
   localparam logic [3:0] ADDR_CONTROL = 4'h8;
   localparam logic [3:0] ADDR_OVF_CLR = 4'hC;

   localparam int unsigned STAT_COUNT_W = 9;
   localparam int unsigned STAT_EMPTY   = 16;
   localparam int unsigned STAT_FULL    = 17;
   localparam int unsigned STAT_OVF     = 18;

   localparam int unsigned CTRL_ENABLE   = 0;
   localparam int unsigned CTRL_FLUSH    = 1;
   localparam int unsigned CTRL_IRQ_MASK = 2;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [0:0] {WrIdle, WrResp} wr_state_e;
   typedef enum logic [0:0] {RdIdle, RdData} rd_state_e;

endpackage

// File: rtl/tx_in_buffer_fifo.sv
// First-word-fall-through FIFO with synchronous flush; head reads 0 while empty.
module tx_in_buffer_fifo #(
   parameter  int unsigned Depth = 16,
   parameter  int unsigned Width = 32,
   localparam int unsigned PtrW  = $clog2(Depth),
   localparam int unsigned CntW  = PtrW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [Width-1:0] wdata,
   input  logic             pop,
   input  logic             flush,
   output logic [Width-1:0] rdata,
   output logic [CntW-1:0]  count,
   output logic             full,
   output logic             empty
);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             do_push, do_pop;

   assign full  = (count_q == CntW'(Depth));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign rdata = empty ? '0 : mem_q[rd_ptr_q];

   // Flush wins over a same-cycle pop; full is judged on the registered count only.
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
         count_d = count_q + CntW'(do_push) - CntW'(do_pop);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/tx_in_buffer.sv
// AXI4-Lite slave queuing CPU-written words for the VLC TX stream.
// Optional irq output and CONTROL[2] mask are enabled by defining TX_IN_BUFFER_IRQ_EN.
module tx_in_buffer
   import tx_in_buffer_pkg::*;
#(
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
   parameter int unsigned FIFO_DEPTH         = 16
) (
   input  logic                            s00_axi_aclk,
   input  logic                            s00_axi_areset,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
   input  logic [2:0]                      s00_axi_awprot,
   input  logic                            s00_axi_awvalid,
   output logic                            s00_axi_awready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
   input  logic                            s00_axi_wvalid,
   output logic                            s00_axi_wready,
   output logic [1:0]                      s00_axi_bresp,
   output logic                            s00_axi_bvalid,
   input  logic                            s00_axi_bready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
   input  logic [2:0]                      s00_axi_arprot,
   input  logic                            s00_axi_arvalid,
   output logic                            s00_axi_arready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
   output logic [1:0]                      s00_axi_rresp,
   output logic                            s00_axi_rvalid,
   input  logic                            s00_axi_rready,
`ifdef TX_IN_BUFFER_IRQ_EN
   output logic                            irq,
`endif
   output logic [C_S_AXI_DATA_WIDTH-1:0]   tx_tdata,
   output logic                            tx_tvalid,
   input  logic                            tx_tready
);

   localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

   wr_state_e                       wr_state_q, wr_state_d;
   rd_state_e                       rd_state_q, rd_state_d;
   logic                            awready_q, awready_d;
   logic                            bvalid_q, bvalid_d;
   logic [1:0]                      bresp_q, bresp_d;
   logic                            arready_q, arready_d;
   logic                            rvalid_q, rvalid_d;
   logic [C_S_AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic                            enable_q, enable_d;
   logic                            ovf_q, ovf_d;
   logic                            mask_q, mask_d;

   logic                            fifo_push, fifo_pop, fifo_flush;
   logic                            fifo_full, fifo_empty;
   logic [CntW-1:0]                 fifo_count;
   logic                            wr_fire, rd_fire;
   logic [3:0]                      wr_addr, rd_addr;
   logic [C_S_AXI_DATA_WIDTH-1:0]   reg_rdata;
   logic                            unused_ok;

   assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_wstrb,
                        s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

   tx_in_buffer_fifo #(
      .Depth (FIFO_DEPTH),
      .Width (C_S_AXI_DATA_WIDTH)
   ) u_fifo (
      .clk   (s00_axi_aclk),
      .rst   (s00_axi_areset),
      .push  (fifo_push),
      .wdata (s00_axi_wdata),
      .pop   (fifo_pop),
      .flush (fifo_flush),
      .rdata (tx_tdata),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign tx_tvalid = enable_q && !fifo_empty;
   assign fifo_pop  = tx_tvalid && tx_tready;

   assign s00_axi_awready = awready_q;
   assign s00_axi_wready  = awready_q;
   assign s00_axi_bvalid  = bvalid_q;
   assign s00_axi_bresp   = bresp_q;
   assign s00_axi_arready = arready_q;
   assign s00_axi_rvalid  = rvalid_q;
   assign s00_axi_rdata   = rdata_q;
   assign s00_axi_rresp   = RESP_OKAY;

   assign wr_addr = {s00_axi_awaddr[3:2], 2'b00};
   assign rd_addr = {s00_axi_araddr[3:2], 2'b00};
   // Ready is a one-cycle registered pulse; the handshake completes on the following edge.
   assign wr_fire = awready_q && s00_axi_awvalid && s00_axi_wvalid;
   assign rd_fire = arready_q && s00_axi_arvalid;

   always_comb begin
      wr_state_d = wr_state_q;
      awready_d  = 1'b0;
      bvalid_d   = bvalid_q;
      bresp_d    = bresp_q;
      enable_d   = enable_q;
      ovf_d      = ovf_q;
      mask_d     = mask_q;
      fifo_push  = 1'b0;
      fifo_flush = 1'b0;
      unique case (wr_state_q)
         WrIdle: begin
            if (wr_fire) begin
               bresp_d = RESP_OKAY;
               case (wr_addr)
                  ADDR_DATA: begin
                     if (fifo_full) begin
                        ovf_d   = 1'b1;
                        bresp_d = RESP_SLVERR;
                     end else begin
                        fifo_push = 1'b1;
                     end
                  end
                  ADDR_CONTROL: begin
                     enable_d   = s00_axi_wdata[CTRL_ENABLE];
                     fifo_flush = s00_axi_wdata[CTRL_FLUSH];
`ifdef TX_IN_BUFFER_IRQ_EN
                     mask_d     = s00_axi_wdata[CTRL_IRQ_MASK];
`endif
                  end
                  ADDR_OVF_CLR: ovf_d = 1'b0;
                  default: ;
               endcase
               bvalid_d   = 1'b1;
               wr_state_d = WrResp;
            end else if (s00_axi_awvalid && s00_axi_wvalid && !awready_q) begin
               awready_d = 1'b1;
            end
         end
         WrResp: begin
            if (s00_axi_bready) begin
               bvalid_d   = 1'b0;
               wr_state_d = WrIdle;
            end
         end
         default: wr_state_d = WrIdle;
      endcase
   end

   always_comb begin
      reg_rdata = '0;
      case (rd_addr)
         ADDR_STATUS: begin
            reg_rdata[STAT_COUNT_W-1:0] = STAT_COUNT_W'(fifo_count);
            reg_rdata[STAT_EMPTY]       = fifo_empty;
            reg_rdata[STAT_FULL]        = fifo_full;
            reg_rdata[STAT_OVF]         = ovf_q;
         end
         ADDR_CONTROL: begin
            reg_rdata[CTRL_ENABLE] = enable_q;
`ifdef TX_IN_BUFFER_IRQ_EN
            reg_rdata[CTRL_IRQ_MASK] = mask_q;
`endif
         end
         default: ;
      endcase
   end

   always_comb begin
      rd_state_d = rd_state_q;
      arready_d  = 1'b0;
      rvalid_d   = rvalid_q;
      rdata_d    = rdata_q;
      unique case (rd_state_q)
         RdIdle: begin
            if (rd_fire) begin
               rdata_d    = reg_rdata;
               rvalid_d   = 1'b1;
               rd_state_d = RdData;
            end else if (s00_axi_arvalid && !arready_q) begin
               arready_d = 1'b1;
            end
         end
         RdData: begin
            if (s00_axi_rready) begin
               rvalid_d   = 1'b0;
               rd_state_d = RdIdle;
            end
         end
         default: rd_state_d = RdIdle;
      endcase
   end

   always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
      if (s00_axi_areset) begin
         wr_state_q <= WrIdle;
         rd_state_q <= RdIdle;
         awready_q  <= 1'b0;
         bvalid_q   <= 1'b0;
         bresp_q    <= RESP_OKAY;
         arready_q  <= 1'b0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         enable_q   <= 1'b0;
         ovf_q      <= 1'b0;
         mask_q     <= 1'b1;
      end else begin
         wr_state_q <= wr_state_d;
         rd_state_q <= rd_state_d;
         awready_q  <= awready_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         arready_q  <= arready_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
         enable_q   <= enable_d;
         ovf_q      <= ovf_d;
         mask_q     <= mask_d;
      end
   end

`ifdef TX_IN_BUFFER_IRQ_EN
   always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
      if (s00_axi_areset) begin
         irq <= 1'b0;
      end else begin
         irq <= !mask_q && (ovf_q || (enable_q && fifo_empty));
      end
   end
`else
   logic unused_mask;
   assign unused_mask = mask_q;
`endif

endmodule

// File: tb/tb_tx_in_buffer.sv
// Self-checking bench for tx_in_buffer: directed steps plus randomized fill/drain rounds.
module tb_tx_in_buffer;

   localparam int DEPTH = 16;

   logic        tb_ACLK = 1'b0;
   logic        areset;
   logic [3:0]  awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] wdata, rdata, tx_tdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;
   logic        tx_tvalid, tx_tready;
`ifdef TX_IN_BUFFER_IRQ_EN
   logic        irq;
`endif

   int n_cmp = 0;
   int n_mis = 0;

   // Reference model state
   logic [31:0] m_q[$];
   bit          m_en;
   bit          m_ovf;
   bit          m_mask;

   always #5 tb_ACLK = ~tb_ACLK;

   tx_in_buffer #(
      .C_S_AXI_DATA_WIDTH (32),
      .C_S_AXI_ADDR_WIDTH (4),
      .FIFO_DEPTH         (DEPTH)
   ) dut (
      .s00_axi_aclk    (tb_ACLK),
      .s00_axi_areset  (areset),
      .s00_axi_awaddr  (awaddr),
      .s00_axi_awprot  (awprot),
      .s00_axi_awvalid (awvalid),
      .s00_axi_awready (awready),
      .s00_axi_wdata   (wdata),
      .s00_axi_wstrb   (wstrb),
      .s00_axi_wvalid  (wvalid),
      .s00_axi_wready  (wready),
      .s00_axi_bresp   (bresp),
      .s00_axi_bvalid  (bvalid),
      .s00_axi_bready  (bready),
      .s00_axi_araddr  (araddr),
      .s00_axi_arprot  (arprot),
      .s00_axi_arvalid (arvalid),
      .s00_axi_arready (arready),
      .s00_axi_rdata   (rdata),
      .s00_axi_rresp   (rresp),
      .s00_axi_rvalid  (rvalid),
      .s00_axi_rready  (rready),
`ifdef TX_IN_BUFFER_IRQ_EN
      .irq             (irq),
`endif
      .tx_tdata        (tx_tdata),
      .tx_tvalid       (tx_tvalid),
      .tx_tready       (tx_tready)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge tb_ACLK);
      #1;
   endtask

   function automatic logic [31:0] exp_status();
      int n;
      logic [31:0] s;
      n = m_q.size();
      s = 32'(n);
      if (n == 0)     s = s + 32'h0001_0000;
      if (n == DEPTH) s = s + 32'h0002_0000;
      if (m_ovf)      s = s + 32'h0004_0000;
      return s;
   endfunction

   function automatic logic [31:0] exp_control();
      logic [31:0] c;
      c = m_en ? 32'd1 : 32'd0;
`ifdef TX_IN_BUFFER_IRQ_EN
      if (m_mask) c = c + 32'd4;
`endif
      return c;
   endfunction

   // Spec-level effect of a register write; assumes no stream pop at the handshake edge.
   task automatic model_write(input logic [3:0] a, input logic [31:0] d, output logic [1:0] r);
      r = 2'b00;
      case (a)
         4'h0: begin
            if (m_q.size() == DEPTH) begin
               m_ovf = 1'b1;
               r     = 2'b10;
            end else begin
               m_q.push_back(d);
            end
         end
         4'h8: begin
            m_en = d[0];
            if (d[1]) m_q.delete();
            m_mask = d[2];
         end
         4'hC: m_ovf = 1'b0;
         default: ;
      endcase
   endtask

   task automatic axi_write(input logic [3:0] a, input logic [31:0] d, output logic [1:0] r);
      awaddr  = a;
      wdata   = d;
      awvalid = 1'b1;
      wvalid  = 1'b1;
      bready  = 1'b1;
      tick();
      check("wr_ready_lat", {30'd0, awready, wready}, 32'd3);
      tick();
      awvalid = 1'b0;
      wvalid  = 1'b0;
      check("wr_bvalid_lat", {30'd0, awready, bvalid}, 32'd1);
      r = bresp;
      tick();
      bready = 1'b0;
      check("wr_bvalid_drop", {31'd0, bvalid}, 32'd0);
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      logic [1:0] er, ar;
      model_write(a, d, er);
      axi_write(a, d, ar);
      check("wr_bresp", {30'd0, ar}, {30'd0, er});
   endtask

   task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
      araddr  = a;
      arvalid = 1'b1;
      tick();
      check("rd_arready_lat", {31'd0, arready}, 32'd1);
      tick();
      arvalid = 1'b0;
      check("rd_rvalid_lat", {30'd0, arready, rvalid}, 32'd1);
      check("rd_rresp", {30'd0, rresp}, 32'd0);
      d      = rdata;
      rready = 1'b1;
      tick();
      rready = 1'b0;
      check("rd_rvalid_drop", {31'd0, rvalid}, 32'd0);
   endtask

   task automatic rd_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
      logic [31:0] d;
      axi_read(a, d);
      check(tag, d, exp);
   endtask

   // Per-cycle stream check; tready either held high or randomized.
   task automatic drain(input int cycles, input bit random_ready);
      bit ev;
      for (int c = 0; c < cycles; c++) begin
         tx_tready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         ev = m_en && (m_q.size() > 0);
         check("stream_tvalid", {31'd0, tx_tvalid}, {31'd0, ev});
         if (ev) check("stream_tdata", tx_tdata, m_q[0]);
         tick();
         if (ev && tx_tready) void'(m_q.pop_front());
      end
      tx_tready = 1'b0;
   endtask

   task automatic model_reset();
      m_q.delete();
      m_en   = 1'b0;
      m_ovf  = 1'b0;
      m_mask = 1'b1;
   endtask

   initial begin
      logic [1:0]  r;
      logic [31:0] d;
      areset = 1'b1;
      awaddr = '0; araddr = '0; awprot = '0; arprot = '0; wdata = '0; wstrb = 4'hF;
      awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0; tx_tready = 0;
      model_reset();

      // Reset state
      repeat (3) tick();
      check("rst_ready", {28'd0, awready, wready, arready, 1'b0}, 32'd0);
      check("rst_valid", {29'd0, bvalid, rvalid, tx_tvalid}, 32'd0);
      check("rst_resp", {28'd0, bresp, rresp}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_tdata", tx_tdata, 32'd0);
      areset = 1'b0;
      tick();
      rd_check("rst_status", 4'h4, 32'h0001_0000);
      rd_check("rst_control", 4'h8, exp_control());

      // Single word with ENABLE=1, tready low
      wr(4'h8, 32'h1);
      wr(4'h0, 32'h0101_FFFF);
      rd_check("one_status", 4'h4, exp_status());
      check("one_tvalid", {31'd0, tx_tvalid}, 32'd1);
      check("one_tdata", tx_tdata, 32'h0101_FFFF);

      // Fill to full, then overflow
      wr(4'h8, 32'h3);
      for (int i = 0; i < DEPTH; i++) wr(4'h0, 32'hABCD_0000 + 32'(i));
      rd_check("full_status", 4'h4, exp_status());
      wr(4'h0, 32'hDEAD_BEEF);
      check("ovf_model", {31'd0, m_ovf}, 32'd1);
      rd_check("ovf_status", 4'h4, exp_status());
      check("ovf_tdata", tx_tdata, 32'hABCD_0000);
      wr(4'hC, 32'h0);
      rd_check("ovfclr_status", 4'h4, exp_status());

      // Full FIFO: pop and DATA write land on the same edge
      awaddr = 4'h0; wdata = 32'h5555_AAAA; awvalid = 1; wvalid = 1; bready = 1;
      tick();
      tx_tready = 1'b1;
      tick();
      tx_tready = 1'b0; awvalid = 0; wvalid = 0;
      check("popwr_bresp", {30'd0, bresp}, 32'd2);
      check("popwr_bvalid", {31'd0, bvalid}, 32'd1);
      void'(m_q.pop_front());
      m_ovf = 1'b1;
      tick();
      bready = 1'b0;
      rd_check("popwr_status", 4'h4, exp_status());
      check("popwr_count", exp_status() & 32'h1FF, 32'd15);
      wr(4'hC, 32'h0);

      // Flush, fill 4, drain at full rate
      wr(4'h8, 32'h3);
      check("flush_tvalid", {31'd0, tx_tvalid}, 32'd0);
      for (int i = 0; i < 4; i++) wr(4'h0, 32'h1000_0000 + 32'(i * 7));
      drain(6, 1'b0);
      rd_check("drain_status", 4'h4, 32'h0001_0000);

      // ENABLE=0 blocks the stream but not pushes
      wr(4'h8, 32'h0);
      tx_tready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wr(4'h0, 32'h2000_0000 + 32'(i));
         check("dis_tvalid", {31'd0, tx_tvalid}, 32'd0);
      end
      tx_tready = 1'b0;
      rd_check("dis_status", 4'h4, exp_status());
      wr(4'h8, 32'h2);
      rd_check("dis_flush_status", 4'h4, 32'h0001_0000);
      rd_check("dis_flush_ctrl", 4'h8, exp_control());
      wr(4'h8, 32'h5);
      rd_check("ctrl_mask_bit", 4'h8, exp_control());

      // Randomized fill/drain rounds
      for (int rnd = 0; rnd < 5; rnd++) begin
         int n;
         n = $urandom_range(1, DEPTH + 3);
         wr(4'h8, 32'h1);
         for (int i = 0; i < n; i++) wr(4'h0, $urandom());
         rd_check("rnd_fill_status", 4'h4, exp_status());
         wr(4'hC, 32'h0);
         drain(40, 1'b1);
         rd_check("rnd_drain_status", 4'h4, exp_status());
      end

      // Reset during the write response phase
      wr(4'h8, 32'h1);
      wr(4'h0, 32'h7777_0001);
      awaddr = 4'h0; wdata = 32'h7777_0002; awvalid = 1; wvalid = 1; bready = 0;
      tick();
      tick();
      awvalid = 0; wvalid = 0;
      check("rstmid_bvalid_pre", {31'd0, bvalid}, 32'd1);
      #2;
      areset = 1'b1;
      #1;
      check("rstmid_bvalid", {31'd0, bvalid}, 32'd0);
      check("rstmid_tvalid", {31'd0, tx_tvalid}, 32'd0);
      model_reset();
      tick();
      areset = 1'b0;
      tick();
      rd_check("rstmid_status", 4'h4, 32'h0001_0000);
      rd_check("rstmid_control", 4'h8, exp_control());

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
